// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge port used by the fetch sequencer.
// The master side (fetch_ctrl) owns the request and the address; the slave
// side (instruction memory) returns the acknowledge and the fetched word.
interface fetch_ctrl_if;
    logic        req;
    logic [63:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the 64-bit PC, issues one fetch at a time
// over the imem interface, holds the fetched word until decode consumes it,
// then requests PC+4 or the taken-branch target. Handles flush/redirect and a
// fetch-timeout watchdog that drops the request for one cycle and retries.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets
// are replaced by TRAP_VECTOR and o_Misalign pulses).
module fetch_ctrl #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          TIMEOUT      = 16
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [63:0] TRAP_VECTOR  = 64'h100
`endif
) (
    input  logic          i_Clock,
    input  logic          i_Reset,
    input  logic          i_Stall,
    input  logic          i_Branch,
    input  logic          i_Zero,
    input  logic [63:0]   i_Immediate,
    input  logic          i_Flush,
    input  logic [63:0]   i_Flush_Addr,
    fetch_ctrl_if.master  imem,
    output logic [31:0]   o_Instr,
    output logic          o_Instr_Valid,
    output logic [63:0]   o_PC,
    output logic          o_Fetch_Err
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic          o_Misalign
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [63:0] fetch_addr, fetch_addr_next;
    logic [31:0] held_instr, held_instr_next;
    logic [63:0] held_pc, held_pc_next;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic        err_pulse, err_pulse_next;
    logic        redirect;
    logic [63:0] redirect_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_pulse, misalign_pulse_next;
`endif

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    // State register: every architectural register reloads here, reset first.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state      <= S_FETCH;
            fetch_addr <= RESET_VECTOR;
            held_instr <= 32'h0;
            held_pc    <= 64'h0;
            wait_cnt   <= 8'h0;
            err_pulse  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_pulse <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            fetch_addr <= fetch_addr_next;
            held_instr <= held_instr_next;
            held_pc    <= held_pc_next;
            wait_cnt   <= wait_cnt_next;
            err_pulse  <= err_pulse_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_pulse <= misalign_pulse_next;
`endif
        end
    end

    // Next-state logic: flush beats everything, then ack/timeout or consume.
    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        held_instr_next = held_instr;
        held_pc_next    = held_pc;
        wait_cnt_next   = wait_cnt;
        err_pulse_next  = 1'b0;
        redirect        = 1'b0;
        redirect_addr   = fetch_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_pulse_next = 1'b0;
`endif

        if (i_Flush) begin
            state_next    = S_FETCH;
            wait_cnt_next = 8'h0;
            redirect      = 1'b1;
            redirect_addr = i_Flush_Addr;
        end else begin
            case (state)
                S_FETCH: begin
                    // During the error cycle the request is dropped, so an
                    // ack is meaningless and the counter stays cleared.
                    if (!err_pulse) begin
                        if (imem.ack) begin
                            state_next      = S_HOLD;
                            held_instr_next = imem.data;
                            held_pc_next    = fetch_addr;
                            wait_cnt_next   = 8'h0;
                        end else if (wait_cnt == LAST_WAIT) begin
                            err_pulse_next = 1'b1;
                            wait_cnt_next  = 8'h0;
                        end else begin
                            wait_cnt_next = wait_cnt + 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_Stall) begin
                        state_next    = S_FETCH;
                        wait_cnt_next = 8'h0;
                        redirect      = 1'b1;
                        redirect_addr = (i_Branch && i_Zero) ? (held_pc + i_Immediate)
                                                             : (held_pc + 64'd4);
                    end
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end

        if (redirect) begin
            fetch_addr_next = redirect_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_addr[1:0] != 2'b00) begin
                fetch_addr_next     = TRAP_VECTOR;
                misalign_pulse_next = 1'b1;
            end
`endif
        end
    end

    // Outputs are decoded straight from the registered state.
    always_comb begin
        imem.req      = (state == S_FETCH) && !err_pulse;
        imem.addr     = fetch_addr;
        o_Instr       = held_instr;
        o_PC          = held_pc;
        o_Instr_Valid = (state == S_HOLD);
        o_Fetch_Err   = err_pulse;
`ifdef FETCH_MISALIGN_TRAP_EN
        o_Misalign    = misalign_pulse;
`endif
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed cases pinned with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

    localparam logic [63:0] RV   = 64'h0;
    localparam int          TMO  = 4;
    localparam logic [63:0] TRAP = 64'h100;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, branch, zero, flush;
    logic [63:0] immediate, flush_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [63:0] pc;
    logic        fetch_err;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    fetch_ctrl_if imem_bus ();

    fetch_ctrl #(
        .RESET_VECTOR (RV),
        .TIMEOUT      (TMO)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .TRAP_VECTOR  (TRAP)
`endif
    ) dut (
        .i_Clock       (clock),
        .i_Reset       (reset),
        .i_Stall       (stall),
        .i_Branch      (branch),
        .i_Zero        (zero),
        .i_Immediate   (immediate),
        .i_Flush       (flush),
        .i_Flush_Addr  (flush_addr),
        .imem          (imem_bus),
        .o_Instr       (instr),
        .o_Instr_Valid (instr_valid),
        .o_PC          (pc),
        .o_Fetch_Err   (fetch_err)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .o_Misalign    (misalign)
`endif
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural model: is an instruction held, is this the error cycle,
    // how long has the current request waited, and what is being fetched.
    bit          m_holding;
    bit          m_err_now;
    bit          m_mis;
    int          m_waited;
    logic [63:0] m_addr;
    logic [63:0] m_pc;
    logic [31:0] m_instr;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [63:0] redirect_to(input logic [63:0] target, output bit mis);
        mis = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (target[1:0] != 2'b00) begin
            mis = 1'b1;
            return TRAP;
        end
`endif
        return target;
    endfunction

    task automatic modelStep(input bit ak, input logic [31:0] dat);
        bit new_err = 1'b0;
        bit new_mis = 1'b0;
        if (reset) begin
            m_holding = 1'b0;
            m_err_now = 1'b0;
            m_mis     = 1'b0;
            m_waited  = 0;
            m_addr    = RV;
            m_pc      = 64'h0;
            m_instr   = 32'h0;
            return;
        end
        if (flush) begin
            m_holding = 1'b0;
            m_waited  = 0;
            m_addr    = redirect_to(flush_addr, new_mis);
        end else if (m_holding) begin
            if (!stall) begin
                m_holding = 1'b0;
                m_waited  = 0;
                m_addr    = redirect_to((branch && zero) ? m_pc + immediate : m_pc + 64'd4, new_mis);
            end
        end else if (!m_err_now) begin
            if (ak) begin
                m_instr   = dat;
                m_pc      = m_addr;
                m_holding = 1'b1;
                m_waited  = 0;
            end else if (m_waited + 1 == TMO) begin
                new_err  = 1'b1;
                m_waited = 0;
            end else begin
                m_waited++;
            end
        end
        m_err_now = new_err;
        m_mis     = new_mis;
    endtask

    task automatic checkOutput();
        check("req", 64'(imem_bus.req), 64'(!m_holding && !m_err_now));
        check("valid", 64'(instr_valid), 64'(m_holding));
        check("fetch_err", 64'(fetch_err), 64'(m_err_now));
        if (!m_holding && !m_err_now) check("addr", imem_bus.addr, m_addr);
        if (m_holding) begin
            check("pc", pc, m_pc);
            check("instr", 64'(instr), 64'(m_instr));
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign", 64'(misalign), 64'(m_mis));
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model,
    // then compare at the next falling edge.
    task automatic applyStimulus(input bit rst, input bit fl, input logic [63:0] fa,
                                 input bit ak, input bit st, input bit br, input bit zr,
                                 input logic [63:0] imm);
        logic [31:0] dat = $urandom;
        reset         = rst;
        flush         = fl;
        flush_addr    = fa;
        imem_bus.ack  = ak;
        imem_bus.data = dat;
        stall         = st;
        branch        = br;
        zero          = zr;
        immediate     = imm;
        modelStep(ak, dat);
        @(posedge clock);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic idle(input bit ak);
        applyStimulus(1'b0, 1'b0, 64'h0, ak, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic flush_to(input logic [63:0] fa, input bit ak);
        applyStimulus(1'b0, 1'b1, fa, ak, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic consume(input bit br, input bit zr, input logic [63:0] imm);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, br, zr, imm);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; flush_addr = '0; stall = 1'b0;
        branch = 1'b0; zero = 1'b0; immediate = '0;
        imem_bus.ack = 1'b0; imem_bus.data = '0;
        @(negedge clock);

        // Reset, then straight-line fetch 0x0, 0x4, 0x8 with immediate acks.
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        check("rst_req", 64'(imem_bus.req), 64'h1);
        check("rst_addr", imem_bus.addr, 64'h0);
        check("rst_valid", 64'(instr_valid), 64'h0);
        check("rst_instr", 64'(instr), 64'h0);
        idle(1'b1);
        check("seq_pc0", pc, 64'h0);
        idle(1'b0);
        check("seq_addr4", imem_bus.addr, 64'h4);
        check("seq_valid_low", 64'(instr_valid), 64'h0);
        idle(1'b1);
        check("seq_pc4", pc, 64'h4);
        idle(1'b0);
        check("seq_addr8", imem_bus.addr, 64'h8);

        // Taken branch from 0x20 by -16, then untaken from 0x20.
        flush_to(64'h20, 1'b0);
        idle(1'b1);
        check("br_pc", pc, 64'h20);
        consume(1'b1, 1'b1, -64'sd16);
        check("br_taken", imem_bus.addr, 64'h10);
        flush_to(64'h20, 1'b0);
        idle(1'b1);
        consume(1'b1, 1'b0, -64'sd16);
        check("br_not_taken", imem_bus.addr, 64'h24);

        // Stall five cycles in hold, then release.
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
            check("stall_req", 64'(imem_bus.req), 64'h0);
            check("stall_pc", pc, 64'h24);
        end
        consume(1'b0, 1'b0, 64'h0);
        check("stall_release", imem_bus.addr, 64'h28);

        // Timeout: four request cycles with no ack, then the error cycle.
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("tmo_no_err_yet", 64'(fetch_err), 64'h0);
        idle(1'b0);
        check("tmo_err", 64'(fetch_err), 64'h1);
        check("tmo_req_low", 64'(imem_bus.req), 64'h0);
        idle(1'b1);
        check("tmo_err_gone", 64'(fetch_err), 64'h0);
        check("tmo_retry_addr", imem_bus.addr, 64'h28);
        check("tmo_ack_ignored", 64'(instr_valid), 64'h0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);
        check("tmo_late_ack_valid", 64'(instr_valid), 64'h1);
        check("tmo_late_ack_no_err", 64'(fetch_err), 64'h0);

        // Flush coinciding with an ack drops the data.
        consume(1'b0, 1'b0, 64'h0);
        flush_to(64'h80, 1'b1);
        check("flush_addr", imem_bus.addr, 64'h80);
        check("flush_valid", 64'(instr_valid), 64'h0);

        // Reset in the middle of a hold.
        idle(1'b1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        check("mid_rst_valid", 64'(instr_valid), 64'h0);
        check("mid_rst_addr", imem_bus.addr, RV);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned branch target is replaced by the trap vector.
        flush_to(64'h20, 1'b0);
        idle(1'b1);
        consume(1'b1, 1'b1, 64'h2);
        check("mis_addr", imem_bus.addr, TRAP);
        check("mis_pulse", 64'(misalign), 64'h1);
        idle(1'b0);
        check("mis_pulse_end", 64'(misalign), 64'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] imm, fa;
            imm = 64'($urandom_range(0, 63)) * 64'd4 - 64'd128;
            if ($urandom_range(0, 7) == 0) imm = imm + 64'($urandom_range(1, 3));
            fa = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) fa[1:0] = 2'b00;
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 19) == 0, fa,
                          $urandom_range(0, 9) < 4,
                          $urandom_range(0, 9) < 3,
                          1'($urandom), 1'($urandom), imm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
